// File: rtl/muxn_rr_pkg.sv
// ============================================================================
// Module   : muxn_rr_pkg
// Purpose  : Shared types and helpers for the round-robin stream multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muxn_rr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Channel index width; never collapses to zero for small channel counts.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muxn_rr_stream_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin search starting at i_ptr, wrapping mod NumCh.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import muxn_rr_pkg::*;
#(
  parameter  int NumCh = 4,
  localparam int IdxW  = idx_w(NumCh)
) (
  input  logic [NumCh-1:0] i_req,
  input  logic [IdxW-1:0]  i_ptr,
  input  logic             i_en,
  output logic [NumCh-1:0] o_gnt,
  output logic [IdxW-1:0]  o_gnt_idx,
  output logic             o_any_gnt
);

  int w_k;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any_gnt = 1'b0;
    w_k       = 0;
    for (int i = 0; i < NumCh; i++) begin
      w_k = (int'(i_ptr) + i) % NumCh;
      if (i_en && !o_any_gnt && i_req[w_k]) begin
        o_gnt[w_k] = 1'b1;
        o_gnt_idx  = IdxW'(w_k);
        o_any_gnt  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muxn_rr_stream.sv
// ============================================================================
// Module   : muxn_rr_stream
// Purpose  : N-channel registered stream mux, round-robin with packet lock.
//            Optional forced selection when MUXN_RR_FORCE_SEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muxn_rr_stream
  import muxn_rr_pkg::*;
#(
  parameter  int Width = 8,
  parameter  int NumCh = 4,
  localparam int IdxW  = idx_w(NumCh)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCh*Width-1:0] a_data_i,
  input  logic [NumCh-1:0]       a_valid_i,
  input  logic [NumCh-1:0]       a_last_i,
  output logic [NumCh-1:0]       a_ready_o,
  output logic [Width-1:0]       y_o,
  output logic                   y_valid_o,
  output logic                   y_last_o,
  input  logic                   y_ready_i,
  output logic [IdxW-1:0]        y_ch_o
`ifdef MUXN_RR_FORCE_SEL_EN
  ,
  input  logic                   force_i,
  input  logic [IdxW-1:0]        force_sel_i
`endif
);

  localparam logic [IdxW-1:0] c_last_idx = IdxW'(NumCh - 1);

  function automatic logic [IdxW-1:0] f_next(input logic [IdxW-1:0] idx);
    return (idx == c_last_idx) ? '0 : idx + IdxW'(1);
  endfunction

  state_e            r_state, w_state_nxt;
  logic [IdxW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IdxW-1:0]   r_lock_ch, w_lock_nxt;
  logic [Width-1:0]  r_y;
  logic              r_y_valid;
  logic              r_y_last;
  logic [IdxW-1:0]   r_y_ch;

  logic              w_load;
  logic              w_fire;
  logic [IdxW-1:0]   w_sel;
  logic [NumCh-1:0]  w_ready;
  logic              w_arb_en;
  logic [NumCh-1:0]  w_arb_gnt;
  logic [IdxW-1:0]   w_arb_idx;
  logic              w_arb_any;

  assign w_load = !r_y_valid || y_ready_i;

`ifdef MUXN_RR_FORCE_SEL_EN
  assign w_arb_en = w_load && !rst_i && (r_state == IDLE) && !force_i;
`else
  assign w_arb_en = w_load && !rst_i && (r_state == IDLE);
`endif

  rr_arbiter #(
    .NumCh (NumCh)
  ) u_arb (
    .i_req     (a_valid_i),
    .i_ptr     (r_rr_ptr),
    .i_en      (w_arb_en),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx),
    .o_any_gnt (w_arb_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_lock_nxt   = r_lock_ch;
    w_fire       = 1'b0;
    w_sel        = '0;
    w_ready      = '0;
    // Reset wins over any transfer in the same cycle.
    if (!rst_i && w_load) begin
      case (r_state)
        IDLE: begin
`ifdef MUXN_RR_FORCE_SEL_EN
          if (force_i) begin
            if ((int'(force_sel_i) < NumCh) && a_valid_i[force_sel_i]) begin
              w_fire               = 1'b1;
              w_sel                = force_sel_i;
              w_ready[force_sel_i] = 1'b1;
              if (!a_last_i[force_sel_i]) begin
                w_state_nxt = LOCKED;
                w_lock_nxt  = force_sel_i;
              end
            end
          end else
`endif
          if (w_arb_any) begin
            w_fire  = 1'b1;
            w_sel   = w_arb_idx;
            w_ready = w_arb_gnt;
            if (a_last_i[w_arb_idx]) begin
              w_rr_ptr_nxt = f_next(w_arb_idx);
            end else begin
              w_state_nxt = LOCKED;
              w_lock_nxt  = w_arb_idx;
            end
          end
        end
        LOCKED: begin
          if (a_valid_i[r_lock_ch]) begin
            w_fire             = 1'b1;
            w_sel              = r_lock_ch;
            w_ready[r_lock_ch] = 1'b1;
            if (a_last_i[r_lock_ch]) begin
              w_state_nxt  = IDLE;
              w_rr_ptr_nxt = f_next(r_lock_ch);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_lock_ch <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_last  <= 1'b0;
      r_y_ch    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_ch <= w_lock_nxt;
      // Data and channel hold when the output drains without refill.
      if (w_load) begin
        r_y_valid <= w_fire;
        if (w_fire) begin
          r_y      <= a_data_i[int'(w_sel)*Width +: Width];
          r_y_last <= a_last_i[w_sel];
          r_y_ch   <= w_sel;
        end
      end
    end
  end

  assign a_ready_o = w_ready;
  assign y_o       = r_y;
  assign y_valid_o = r_y_valid;
  assign y_last_o  = r_y_last;
  assign y_ch_o    = r_y_ch;

endmodule

`default_nettype wire

// File: tb/tb_muxn_rr_stream.sv
// ============================================================================
// Module   : tb_muxn_rr_stream
// Purpose  : Directed self-checking bench for muxn_rr_stream (4- and 3-channel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muxn_rr_stream;

  logic        clk;
  logic        rst;
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_last, a_ready;
  logic [7:0]  y;
  logic        y_valid, y_last, y_ready;
  logic [1:0]  y_ch;

  logic [23:0] d3_data;
  logic [2:0]  v3, l3, r3;
  logic [7:0]  y3;
  logic        yv3, yl3, yr3;
  logic [1:0]  ch3;

  int n_tests = 0;
  int n_fail  = 0;

  muxn_rr_stream #(.Width(8), .NumCh(4)) dut4 (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_data_i  (a_data),
    .a_valid_i (a_valid),
    .a_last_i  (a_last),
    .a_ready_o (a_ready),
    .y_o       (y),
    .y_valid_o (y_valid),
    .y_last_o  (y_last),
    .y_ready_i (y_ready),
    .y_ch_o    (y_ch)
  );

  muxn_rr_stream #(.Width(8), .NumCh(3)) dut3 (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_data_i  (d3_data),
    .a_valid_i (v3),
    .a_last_i  (l3),
    .a_ready_o (r3),
    .y_o       (y3),
    .y_valid_o (yv3),
    .y_last_o  (yl3),
    .y_ready_i (yr3),
    .y_ch_o    (ch3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ey, input logic [1:0] ech,
                         input logic ev, input logic el);
    chk({tag, "_y"},     32'(y),       32'(ey));
    chk({tag, "_ch"},    32'(y_ch),    32'(ech));
    chk({tag, "_valid"}, 32'(y_valid), 32'(ev));
    chk({tag, "_last"},  32'(y_last),  32'(el));
  endtask

  initial begin
    rst = 1'b1; a_valid = 4'hF; a_last = 4'hF; a_data = 32'h30201000; y_ready = 1'b1;
    v3 = 3'b000; l3 = 3'b111; d3_data = 24'h0; yr3 = 1'b1;

    // Reset held two cycles with every channel requesting
    tick();
    chk("rst_ready_a", 32'(a_ready), 32'h0);
    tick();
    chk_out("rst", 8'h00, 2'd0, 1'b0, 1'b0);
    chk("rst_ready_b", 32'(a_ready), 32'h0);
    chk("rst3_valid", 32'(yv3), 32'h0);
    chk("rst3_ch", 32'(ch3), 32'h0);

    // Round-robin over single-beat packets
    rst = 1'b0;
    #1 chk("rr_ready0", 32'(a_ready), 32'h1);
    tick();
    chk_out("rr0", 8'h00, 2'd0, 1'b1, 1'b1);
    a_data = 32'h30201001;
    #1 chk("rr_ready1", 32'(a_ready), 32'h2);
    tick(); chk_out("rr1", 8'h10, 2'd1, 1'b1, 1'b1);
    tick(); chk_out("rr2", 8'h20, 2'd2, 1'b1, 1'b1);
    tick(); chk_out("rr3", 8'h30, 2'd3, 1'b1, 1'b1);
    tick(); chk_out("rr4", 8'h01, 2'd0, 1'b1, 1'b1);

    // Drain without refill: valid drops, data and channel hold
    a_valid = 4'h0;
    tick(); chk_out("drain", 8'h01, 2'd0, 1'b0, 1'b1);

    // Packet lock: ch1 3-beat packet while ch2 stays valid
    a_valid = 4'b0110; a_last = 4'b0100; a_data = 32'h00504100;
    #1 chk("lock_ready0", 32'(a_ready), 32'h2);
    tick(); chk_out("lock0", 8'h41, 2'd1, 1'b1, 1'b0);
    a_data = 32'h00504200;
    #1 chk("lock_ready1", 32'(a_ready), 32'h2);
    tick(); chk_out("lock1", 8'h42, 2'd1, 1'b1, 1'b0);
    a_data = 32'h00504300; a_last = 4'b0110;
    #1 chk("lock_ready2", 32'(a_ready), 32'h2);
    tick(); chk_out("lock2", 8'h43, 2'd1, 1'b1, 1'b1);
    a_valid = 4'b0100;
    #1 chk("lock_ready3", 32'(a_ready), 32'h4);
    tick(); chk_out("after_lock", 8'h50, 2'd2, 1'b1, 1'b1);

    // Backpressure: output frozen, no input accepted
    a_valid = 4'b1000; a_last = 4'hF; a_data = 32'hA5000000;
    tick(); chk_out("bp_load", 8'hA5, 2'd3, 1'b1, 1'b1);
    y_ready = 1'b0; a_valid = 4'b1001; a_data = 32'hA5000077;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(a_ready), 32'h0);
      tick(); chk_out("bp_hold", 8'hA5, 2'd3, 1'b1, 1'b1);
    end
    y_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(a_ready), 32'h1);
    tick(); chk_out("bp_release", 8'h77, 2'd0, 1'b1, 1'b1);
    a_valid = 4'h0;
    tick(); chk_out("bp_drain", 8'h77, 2'd0, 1'b0, 1'b1);

    // Mid-packet reset while ch3 is locked
    a_valid = 4'b1000; a_last = 4'h0; a_data = 32'hC0000000;
    tick(); chk_out("mr0", 8'hC0, 2'd3, 1'b1, 1'b0);
    a_data = 32'hC1000000;
    tick(); chk_out("mr1", 8'hC1, 2'd3, 1'b1, 1'b0);
    rst = 1'b1; a_data = 32'hC2000000;
    #1 chk("mr_rst_ready", 32'(a_ready), 32'h0);
    tick(); chk_out("mr_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; a_valid = 4'hF; a_last = 4'hF;
    #1 chk("mr_ready", 32'(a_ready), 32'h1);
    tick(); chk_out("mr_first", 8'h00, 2'd0, 1'b1, 1'b1);

    // Non-power-of-two wrap on the 3-channel instance
    v3 = 3'b010; d3_data = 24'h2A1B0A;
    tick();
    chk("w3_ch1", 32'(ch3), 32'd1);
    chk("w3_y1", 32'(y3), 32'h1B);
    v3 = 3'b101;
    tick(); chk("w3_ch_a", 32'(ch3), 32'd2); chk("w3_y_a", 32'(y3), 32'h2A);
    tick(); chk("w3_ch_b", 32'(ch3), 32'd0); chk("w3_y_b", 32'(y3), 32'h0A);
    tick(); chk("w3_ch_c", 32'(ch3), 32'd2); chk("w3_valid_c", 32'(yv3), 32'd1);
    tick(); chk("w3_ch_d", 32'(ch3), 32'd0); chk("w3_last_d", 32'(yl3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
